pc_sequencer: RTL and testbench

Multi-cycle program counter for the single-issue core. It advances once per instruction slot of `CPI` clock cycles and supports:
- absolute and PC-relative jumps,
- call/return through an internal return-address stack (RAS),
- pipeline stall and halt.

It sits in the fetch stage, drives the instruction-memory address, and exposes a one-cycle commit strobe that downstream stages use as their instruction-boundary marker.

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter that advances once per instruction slot of
//   CPI clock cycles. Supports absolute and PC-relative jumps, call/return
//   through an internal return-address stack (RAS), stall and a sticky halt.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   stall                 freezes the phase counter and all state
//   halt                  at a commit, stop sequencing until reset
//   branch_en, branch_rel jump at the commit; relative = signed offset
//   call, ret             push prog_ctr+1 and jump / pop and jump
//   target [D-1:0]        jump address or two's-complement offset
//   prog_ctr [D-1:0]      current instruction address
//   phase [4:0]           cycle index within the slot, 0..CPI-1
//   step                  one-cycle strobe following each commit
//   halted                sticky halt flag
//   ras_empty, ras_full   RAS occupancy flags
//   ras_err               sticky RAS overflow/underflow flag
module pc_sequencer #(
  parameter int D         = 12,
  parameter int CPI       = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic         call,
  input  logic         ret,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic [4:0]   phase,
  output logic         step,
  output logic         halted,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [4:0]    LAST_PHASE = 5'(CPI - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(RAS_DEPTH);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [4:0]    phase_q, phase_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D-1:0]  ras_q [RAS_DEPTH];
  logic [D-1:0]  ras_d [RAS_DEPTH];

  logic                commit;
  logic                ras_is_empty;
  logic                ras_is_full;
  logic [AW-1:0]       push_idx;
  logic [AW-1:0]       pop_idx;
  logic signed [D-1:0] offset;
  logic [D-1:0]        pc_inc;
  logic [D-1:0]        jump_pc;

  // Address arithmetic wraps modulo 2^D; the offset is two's complement.
  function automatic logic [D-1:0] pc_add(input logic [D-1:0] base,
                                          input logic signed [D-1:0] off);
    return base + $unsigned(off);
  endfunction

  assign offset       = target;
  assign pc_inc       = pc_q + D'(1);
  assign jump_pc      = branch_rel ? pc_add(pc_q, offset) : target;
  assign ras_is_empty = (cnt_q == '0);
  assign ras_is_full  = (cnt_q == FULL_CNT);
  assign push_idx     = cnt_q[AW-1:0];
  assign pop_idx      = AW'(cnt_q - CW'(1));
  assign commit       = (state_q == S_RUN) && !stall && (phase_q == LAST_PHASE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ras_d   = ras_q;

    if (state_q == S_HALT) begin
      phase_d = '0;
    end else if (!stall) begin
      if (commit) begin
        phase_d = '0;
        step_d  = 1'b1;
        if (halt) begin
          state_d = S_HALT;
        end else if (ret) begin
          // Underflow still advances sequentially so fetch never stalls.
          if (!ras_is_empty) begin
            pc_d  = ras_q[pop_idx];
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end
        end else if (call) begin
          // Overflow drops the return address but the jump is still taken.
          if (!ras_is_full) begin
            ras_d[push_idx] = pc_inc;
            cnt_d           = cnt_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
          pc_d = jump_pc;
        end else if (branch_en) begin
          pc_d = jump_pc;
        end else begin
          pc_d = pc_inc;
        end
      end else begin
        phase_d = phase_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      phase_q <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack entries are qualified by cnt_q, so they need no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign prog_ctr  = pc_q;
  assign phase     = phase_q;
  assign step      = step_q;
  assign halted    = (state_q == S_HALT);
  assign ras_empty = ras_is_empty;
  assign ras_full  = ras_is_full;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int D         = 12;
  localparam int CPI       = 5;
  localparam int RAS_DEPTH = 4;
  localparam int MOD       = 1 << D;

  logic         clk = 1'b0;
  logic         reset, stall, halt, branch_en, branch_rel, call, ret;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic [4:0]   phase;
  logic         step, halted, ras_empty, ras_full, ras_err;

  pc_sequencer #(.D(D), .CPI(CPI), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_rel(branch_rel), .call(call), .ret(ret),
    .target(target), .prog_ctr(prog_ctr), .phase(phase), .step(step),
    .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Slot-level reference model
  int m_pc, m_phase;
  bit m_step, m_halted, m_err;
  int m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("prog_ctr",  32'(prog_ctr),  32'(m_pc));
    chk("phase",     32'(phase),     32'(m_phase));
    chk("step",      32'(step),      32'(m_step));
    chk("halted",    32'(halted),    32'(m_halted));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full",  32'(ras_full),  32'(m_ras.size() == RAS_DEPTH));
    chk("ras_err",   32'(ras_err),   32'(m_err));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      stall      = 1'($urandom_range(0, 1));
      halt       = 1'($urandom_range(0, 1));
      branch_en  = 1'($urandom_range(0, 1));
      branch_rel = 1'($urandom_range(0, 1));
      call       = 1'($urandom_range(0, 1));
      ret        = 1'($urandom_range(0, 1));
      target     = D'($urandom);
      @(posedge clk);
      m_pc = 0; m_phase = 0; m_step = 0; m_halted = 0; m_err = 0;
      m_ras.delete();
      #1 check_all();
    end
    reset = 1'b0;
  endtask

  // One clock cycle. Control values are applied only if this edge is a
  // commit; on every other edge they are randomised and must be ignored.
  task automatic cyc(input bit st, input bit h, input bit br, input bit rel,
                     input bit c, input bit r, input logic [D-1:0] tgt);
    bit will_commit;
    int off, jt;
    will_commit = !m_halted && !st && (m_phase == CPI - 1);
    stall = st;
    if (will_commit) begin
      halt = h; branch_en = br; branch_rel = rel; call = c; ret = r; target = tgt;
    end else begin
      halt       = 1'($urandom_range(0, 1));
      branch_en  = 1'($urandom_range(0, 1));
      branch_rel = 1'($urandom_range(0, 1));
      call       = 1'($urandom_range(0, 1));
      ret        = 1'($urandom_range(0, 1));
      target     = D'($urandom);
    end
    @(posedge clk);
    if (st) begin
      m_step = 0;
    end else if (m_halted) begin
      m_step = 0; m_phase = 0;
    end else if (!will_commit) begin
      m_step = 0; m_phase++;
    end else begin
      m_step = 1; m_phase = 0;
      off = (int'(tgt) >= MOD / 2) ? int'(tgt) - MOD : int'(tgt);
      jt  = rel ? (m_pc + off + MOD) % MOD : int'(tgt);
      if (h) m_halted = 1;
      else if (r) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = (m_pc + 1) % MOD; m_err = 1; end
      end else if (c) begin
        if (m_ras.size() < RAS_DEPTH) m_ras.push_back((m_pc + 1) % MOD);
        else m_err = 1;
        m_pc = jt;
      end else if (br) m_pc = jt;
      else m_pc = (m_pc + 1) % MOD;
    end
    #1 check_all();
  endtask

  task automatic commit_with(input bit h, input bit br, input bit rel,
                             input bit c, input bit r, input logic [D-1:0] tgt);
    int guard = 0;
    while (m_phase != CPI - 1 && guard < CPI + 1) begin
      cyc(0, 0, 0, 0, 0, 0, '0);
      guard++;
    end
    chk("commit_reachable", 32'(m_phase == CPI - 1), 32'(1));
    cyc(0, h, br, rel, c, r, tgt);
  endtask

  int exp_ret[4] = '{'h321, 'h311, 'h301, 'h022};

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0; branch_en = 1'b0;
    branch_rel = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
    do_reset(2);

    // Idle sequencing: four commits in twenty cycles
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, '0);
    chk("idle_pc", 32'(prog_ctr), 32'h4);
    chk("idle_step", 32'(step), 32'h1);

    repeat (6) commit_with(0, 0, 0, 0, 0, '0);
    chk("pc_ten", 32'(prog_ctr), 32'd10);
    commit_with(0, 1, 1, 0, 0, 12'hFFD);
    chk("rel_jump", 32'(prog_ctr), 32'd7);
    commit_with(0, 1, 0, 0, 0, 12'h200);
    chk("abs_jump", 32'(prog_ctr), 32'h200);
    commit_with(0, 1, 0, 0, 0, 12'hFFF);
    commit_with(0, 0, 0, 0, 0, '0);
    chk("wrap", 32'(prog_ctr), 32'h000);

    // Single call/return
    commit_with(0, 1, 0, 0, 0, 12'h020);
    commit_with(0, 0, 0, 1, 0, 12'h100);
    chk("call_pc", 32'(prog_ctr), 32'h100);
    chk("call_nonempty", 32'(ras_empty), 32'h0);
    commit_with(0, 0, 0, 0, 0, '0);
    commit_with(0, 0, 0, 0, 1, '0);
    chk("ret_pc", 32'(prog_ctr), 32'h021);
    chk("ret_empty", 32'(ras_empty), 32'h1);
    chk("ret_noerr", 32'(ras_err), 32'h0);

    // Nested calls to overflow, then unwinding past empty
    for (int i = 0; i < 5; i++) begin
      commit_with(0, 0, 0, 1, 0, D'('h300 + 16 * i));
      if (i == 3) begin
        chk("full_after4", 32'(ras_full), 32'h1);
        chk("noerr_after4", 32'(ras_err), 32'h0);
      end
    end
    chk("ovf_pc", 32'(prog_ctr), 32'h340);
    chk("ovf_err", 32'(ras_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      commit_with(0, 1, 0, 1, 1, 12'h555);
      chk("lifo_pc", 32'(prog_ctr), 32'(exp_ret[i]));
    end
    commit_with(0, 0, 0, 0, 1, '0);
    chk("unf_pc", 32'(prog_ctr), 32'h023);
    chk("unf_err", 32'(ras_err), 32'h1);

    // Stall at phase 2 delays the commit by exactly three cycles
    do_reset(1);
    cyc(0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("stall_phase", 32'(phase), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("stall_nocommit", 32'(prog_ctr), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("stall_commit", 32'(prog_ctr), 32'h1);
    chk("stall_step", 32'(step), 32'h1);

    // Halt is sticky until reset
    commit_with(0, 1, 0, 0, 0, 12'h030);
    commit_with(1, 1, 0, 0, 0, 12'h444);
    chk("halt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), 0, 1'(i % 2), 0, 0, 0, 12'h123);
    chk("halt_hold", 32'(prog_ctr), 32'h030);
    do_reset(1);
    chk("post_reset_pc", 32'(prog_ctr), 32'h0);
    chk("post_reset_halt", 32'(halted), 32'h0);

    // Randomised traffic, with occasional mid-slot resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0 || (m_halted && $urandom_range(0, 9) == 0))
        do_reset(1);
      else
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, D'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
